// File: rtl/upload_pkg.sv
// Shared constants and types for the USB upload path: source tags, arbiter
// state encoding and a width helper for the stall watchdog.
package upload_pkg;

  localparam logic [7:0] SRC_UART = 8'h01;
  localparam logic [7:0] SRC_I2C  = 8'h02;
  localparam logic [7:0] SRC_SPI  = 8'h03;
  localparam logic [7:0] SRC_ADC  = 8'h04;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Watchdog counter width; a disabled watchdog (0) still needs one bit.
  function automatic int cnt_width(input int t);
    return (t <= 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational next-grant picker: round-robin from i_ptr+1, or fixed priority
// (lowest index wins) when PRIO_MODE is 1. Outputs a one-hot grant and its index.
module rr_arbiter #(
  parameter int N_SRC     = 4,
  parameter int PRIO_MODE = 0,
  parameter int IW        = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_SRC-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  int          w_pos;
  logic [IW-1:0] w_j;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = |i_req;
    w_pos   = 0;
    w_j     = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      if (PRIO_MODE != 0) w_pos = k - 1;
      else                w_pos = (int'(i_ptr) + k) % N_SRC;
      w_j = IW'(w_pos);
      if (i_req[w_j]) begin
        o_grant = N_SRC'(1) << w_j;
        o_idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/upload_arbiter.sv
// Shares the USB upload path between N_SRC handlers with packet-granular
// locking, a stall watchdog that evicts a silent owner, and an eviction mask.
module upload_arbiter
  import upload_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int PRIO_MODE   = 0,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   src_req,
  input  logic [N_SRC*8-1:0] src_data,
  input  logic [N_SRC*8-1:0] src_source,
  input  logic [N_SRC-1:0]   src_valid,
  output logic [N_SRC-1:0]   src_ready,
  output logic               up_req,
  output logic [7:0]         up_data,
  output logic [7:0]         up_source,
  output logic               up_valid,
  input  logic               up_ready,
  output logic [N_SRC-1:0]   arb_grant,
  output logic               timeout_err
);

  localparam int IW = $clog2(N_SRC);
  localparam int CW = cnt_width(TIMEOUT_CYC);

  state_e           r_state;
  logic [N_SRC-1:0] r_grant;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [N_SRC-1:0] r_mask;
  logic             r_tout;

  logic [N_SRC-1:0] w_pick_grant;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic             w_busy;
  logic             w_xfer;
  logic [CW-1:0]    w_cnt_nx;
  logic             w_expire;

  rr_arbiter #(
    .N_SRC     (N_SRC),
    .PRIO_MODE (PRIO_MODE),
    .IW        (IW)
  ) u_pick (
    .i_req   (src_req & ~r_mask),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_busy   = (r_state == ST_BUSY);
  assign w_xfer   = src_valid[r_idx] & up_ready;
  assign w_cnt_nx = (&r_cnt) ? r_cnt : r_cnt + CW'(1);
  assign w_expire = (TIMEOUT_CYC != 0) && (w_cnt_nx == CW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= IW'(N_SRC - 1);
      r_cnt   <= '0;
      r_mask  <= '0;
      r_tout  <= 1'b0;
    end else begin
      r_tout <= 1'b0;
      // An evicted source becomes eligible again once it drops its request.
      r_mask <= r_mask & src_req;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_grant <= w_pick_grant;
            r_idx   <= w_pick_idx;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!src_req[r_idx]) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= r_idx;
          end else if (w_xfer) begin
            r_cnt <= '0;
          end else if (w_expire) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_ptr         <= r_idx;
            r_mask[r_idx] <= 1'b1;
            r_tout        <= 1'b1;
          end else begin
            r_cnt <= w_cnt_nx;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign up_req      = w_busy & src_req[r_idx];
  assign up_valid    = w_busy & src_valid[r_idx];
  assign up_data     = w_busy ? src_data[{r_idx, 3'b000} +: 8] : 8'h00;
  assign up_source   = w_busy ? src_source[{r_idx, 3'b000} +: 8] : 8'h00;
  assign src_ready   = (w_busy & up_ready) ? r_grant : '0;
  assign arb_grant   = r_grant;
  assign timeout_err = r_tout;

endmodule
